// File: rtl/mmio_irq_timer_pkg.sv
// Shared definitions for the mmio_irq_timer peripheral: register offsets,
// PEND/CTRL bit positions and the address-to-register decode.
package mmio_irq_timer_pkg;

  localparam logic [4:0] PEND_OFS  = 5'h00;
  localparam logic [4:0] MASK_OFS  = 5'h04;
  localparam logic [4:0] LOAD_OFS  = 5'h08;
  localparam logic [4:0] COUNT_OFS = 5'h0C;
  localparam logic [4:0] CTRL_OFS  = 5'h10;
  localparam logic [4:0] SWI_OFS   = 5'h14;

  localparam int IRQ_TIMER = 6;
  localparam int IRQ_SW    = 7;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;

  typedef enum logic [2:0] {
    SEL_PEND,
    SEL_MASK,
    SEL_LOAD,
    SEL_COUNT,
    SEL_CTRL,
    SEL_SWI,
    SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    logic pend;
    logic mask;
    logic load;
    logic ctrl;
    logic swi;
  } wr_strb_t;

  // Byte-lane bits [1:0] are ignored; 0x18/0x1C fall through to SEL_NONE.
  function automatic reg_sel_e ofs_to_sel(input logic [4:0] ofs);
    logic [4:0] word_ofs;
    word_ofs = {ofs[4:2], 2'b00};
    case (word_ofs)
      PEND_OFS:  return SEL_PEND;
      MASK_OFS:  return SEL_MASK;
      LOAD_OFS:  return SEL_LOAD;
      COUNT_OFS: return SEL_COUNT;
      CTRL_OFS:  return SEL_CTRL;
      SWI_OFS:   return SEL_SWI;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_irq_timer_edge_detect.sv
// Rising-edge detector for the external request lines: one-cycle pulse
// when a line is high now and was low on the previous clock.
module irq_edge_detect #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= level_i;
    end
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/mmio_irq_timer.sv
// Memory-mapped interrupt controller with an interval timer: latches external,
// timer and software requests as pending, masks them and drives interrupts.
module mmio_irq_timer
  import mmio_irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
  parameter int          NUM_EXT   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               memwrite,
  input  logic               memread,
  input  logic [31:0]        dataadr,
  input  logic [31:0]        writedata,
  input  logic [NUM_EXT-1:0] ext_irq,
  output logic [31:0]        readdata,
  output logic [7:0]         interrupts
);

  logic        hit;
  reg_sel_e    sel;
  wr_strb_t    wr;
  logic        rd_en;
  logic        unused_adr;

  logic [7:0]  pend_q, pend_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] readdata_q, readdata_d;
  logic [7:0]  irq_q, irq_d;

  logic [NUM_EXT-1:0] ext_rise;
  logic [5:0]         ext_set;
  logic               tick;
  logic               expire;
  logic [7:0]         set_vec;
  logic [7:0]         clr_vec;

  assign unused_adr = ^dataadr[1:0];

  // ---------------------------------------------------------------- decode
  assign hit   = (dataadr[31:5] == BASE_ADDR[31:5]);
  assign sel   = ofs_to_sel(dataadr[4:0]);
  assign rd_en = memread & hit;

  always_comb begin
    wr = '0;
    if (memwrite && hit) begin
      case (sel)
        SEL_PEND: wr.pend = 1'b1;
        SEL_MASK: wr.mask = 1'b1;
        SEL_LOAD: wr.load = 1'b1;
        SEL_CTRL: wr.ctrl = 1'b1;
        SEL_SWI:  wr.swi  = 1'b1;
        default:  wr      = '0;
      endcase
    end
  end

  // --------------------------------------------------------- ext requests
  irq_edge_detect #(
    .WIDTH (NUM_EXT)
  ) u_edge (
    .clk     (clk),
    .reset   (reset),
    .level_i (ext_irq),
    .rise_o  (ext_rise)
  );

  assign ext_set = 6'(ext_rise);

  // ---------------------------------------------------------------- timer
  assign tick   = ctrl_q[CTRL_EN] && (count_q != 32'd0);
  assign expire = tick && (count_q == 32'd1);

  always_comb begin
    count_d = count_q;
    ctrl_d  = ctrl_q;
    if (expire) begin
      if (ctrl_q[CTRL_AUTO] && (load_q != 32'd0)) begin
        count_d = load_q;
      end else begin
        count_d         = 32'd0;
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end else if (tick) begin
      count_d = count_q - 32'd1;
    end
    // Software writes are applied last so they override the timer's own update.
    if (wr.load) begin
      count_d = writedata;
    end
    if (wr.ctrl) begin
      ctrl_d = writedata[1:0];
    end
  end

  // ------------------------------------------------------ register file
  always_comb begin
    set_vec            = {2'b00, ext_set};
    set_vec[IRQ_TIMER] = expire;
    set_vec[IRQ_SW]    = wr.swi & writedata[0];
    clr_vec            = wr.pend ? writedata[7:0] : 8'h00;
    // New requests beat a simultaneous W1C so no event is lost.
    pend_d             = (pend_q & ~clr_vec) | set_vec;
  end

  always_comb begin
    mask_d = mask_q;
    load_d = load_q;
    if (wr.mask) begin
      mask_d = writedata[7:0];
    end
    if (wr.load) begin
      load_d = writedata;
    end
  end

  assign irq_d = pend_q & mask_q;

  // Reads always see the register contents from before this cycle's write.
  always_comb begin
    readdata_d = 32'd0;
    if (rd_en) begin
      case (sel)
        SEL_PEND:  readdata_d = {24'd0, pend_q};
        SEL_MASK:  readdata_d = {24'd0, mask_q};
        SEL_LOAD:  readdata_d = load_q;
        SEL_COUNT: readdata_d = count_q;
        SEL_CTRL:  readdata_d = {30'd0, ctrl_q};
        default:   readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 8'h00;
      mask_q     <= 8'h00;
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      ctrl_q     <= 2'b00;
      readdata_q <= 32'd0;
      irq_q      <= 8'h00;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      load_q     <= load_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata   = readdata_q;
  assign interrupts = irq_q;

endmodule

// File: tb/tb_mmio_irq_timer.sv
// Self-checking bench for mmio_irq_timer: directed vector table, hand-written
// timer/reset sequences and random traffic against a behavioural model.
module tb_mmio_irq_timer;

  localparam logic [31:0] BASE = 32'h0000_FF00;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [5:0]  ext_irq;
  logic [31:0] readdata;
  logic [7:0]  interrupts;

  int n_chk = 0;
  int n_err = 0;

  mmio_irq_timer #(
    .BASE_ADDR (BASE),
    .NUM_EXT   (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .memread    (memread),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .ext_irq    (ext_irq),
    .readdata   (readdata),
    .interrupts (interrupts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ model
  logic [7:0]  m_pend, m_mask, m_irq;
  logic [31:0] m_load, m_count, m_rd;
  logic        m_en, m_auto;
  logic [5:0]  m_prev;

  function automatic logic [31:0] m_read(input logic [4:0] o);
    case (o)
      5'h00:   return {24'd0, m_pend};
      5'h04:   return {24'd0, m_mask};
      5'h08:   return m_load;
      5'h0C:   return m_count;
      5'h10:   return {30'd0, m_auto, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clock(input logic rst, input logic we, input logic re,
                             input logic [31:0] adr, input logic [31:0] wd,
                             input logic [5:0] ext);
    logic       in_win;
    logic [4:0] o;
    logic [7:0] sets, clr;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_irq = 0; m_load = 0; m_count = 0;
      m_rd = 0; m_en = 0; m_auto = 0; m_prev = 0;
      return;
    end
    in_win = ((adr >> 5) == (BASE >> 5));
    o      = adr[4:0] & 5'h1C;
    m_rd   = (re && in_win) ? m_read(o) : 32'd0;
    m_irq  = m_pend & m_mask;
    sets   = {2'b00, ext & ~m_prev};
    clr    = 8'h00;
    if (m_en && m_count != 0) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        sets[6] = 1'b1;
        if (m_auto && m_load != 0) m_count = m_load;
        else m_en = 1'b0;
      end
    end
    if (we && in_win) begin
      case (o)
        5'h00: clr = wd[7:0];
        5'h04: m_mask = wd[7:0];
        5'h08: begin m_load = wd; m_count = wd; end
        5'h10: begin m_en = wd[0]; m_auto = wd[1]; end
        5'h14: if (wd[0]) sets[7] = 1'b1;
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | sets;
    m_prev = ext;
  endtask

  // ------------------------------------------------------------ helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [31:0] adr, input logic [31:0] wd,
                      input logic [5:0] ext);
    reset = rst; memwrite = we; memread = re;
    dataadr = adr; writedata = wd; ext_irq = ext;
    model_clock(rst, we, re, adr, wd, ext);
    @(posedge clk);
    #1;
    chk("model_readdata", readdata, m_rd);
    chk("model_interrupts", {24'd0, interrupts}, {24'd0, m_irq});
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, BASE + 32'(o), d, ext_irq);
  endtask

  task automatic rd(input logic [4:0] o);
    step(1'b0, 1'b0, 1'b1, BASE + 32'(o), 32'd0, ext_irq);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [5:0]  ext;
    logic [31:0] exp_rd;
    logic [7:0]  exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic re, input logic [31:0] adr,
                     input logic [31:0] wd, input logic [5:0] ext,
                     input logic [31:0] exp_rd, input logic [7:0] exp_irq);
    vec_t v;
    v.we = we; v.re = re; v.adr = adr; v.wd = wd; v.ext = ext;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endtask

  initial begin
    int          highs;
    int          last_hi;
    int          found;
    logic [31:0] prev_cnt;
    logic [4:0]  word;
    logic        off;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [5:0]  ext;

    reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
    dataadr = 32'd0; writedata = 32'd0; ext_irq = 6'd0;

    // reset reads, ext edge latency, W1C, SWI, off-window, read+write
    for (int i = 0; i < 8; i++) add(0, 1, BASE + 32'(i * 4), 0, 0, 32'h0, 8'h00);
    add(1, 0, BASE + 32'h04, 32'h1,  6'h0, 32'h0,  8'h00);
    add(0, 0, BASE,          0,      6'h1, 32'h0,  8'h00);
    add(0, 0, BASE,          0,      6'h0, 32'h0,  8'h01);
    add(0, 1, BASE + 32'h00, 0,      6'h0, 32'h1,  8'h01);
    add(1, 0, BASE + 32'h00, 32'h1,  6'h0, 32'h0,  8'h01);
    add(0, 0, BASE,          0,      6'h0, 32'h0,  8'h00);
    add(0, 1, BASE + 32'h00, 0,      6'h0, 32'h0,  8'h00);
    add(1, 0, BASE + 32'h04, 32'h80, 6'h0, 32'h0,  8'h00);
    add(1, 0, BASE + 32'h14, 32'h1,  6'h0, 32'h0,  8'h00);
    add(0, 0, BASE,          0,      6'h0, 32'h0,  8'h80);
    add(1, 0, BASE + 32'h40, 32'hFFFF_FFFF, 6'h0, 32'h0, 8'h80);
    add(0, 1, BASE + 32'h04, 0,      6'h0, 32'h80, 8'h80);
    add(0, 1, BASE + 32'h08, 0,      6'h0, 32'h0,  8'h80);
    add(0, 1, BASE + 32'h00, 0,      6'h0, 32'h80, 8'h80);
    add(0, 1, BASE + 32'h44, 0,      6'h0, 32'h0,  8'h80);
    add(1, 0, BASE + 32'h00, 32'h80, 6'h0, 32'h0,  8'h80);
    add(0, 0, BASE,          0,      6'h0, 32'h0,  8'h00);
    add(1, 1, BASE + 32'h04, 32'h3C, 6'h0, 32'h80, 8'h00);
    add(0, 1, BASE + 32'h04, 0,      6'h0, 32'h3C, 8'h00);
    add(1, 0, BASE + 32'h04, 32'h0,  6'h0, 32'h0,  8'h00);

    do_reset();
    do_reset();
    chk("reset_interrupts", {24'd0, interrupts}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].we, vecs[i].re, vecs[i].adr, vecs[i].wd, vecs[i].ext);
      chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_interrupts", i), {24'd0, interrupts}, {24'd0, vecs[i].exp_irq});
    end

    // auto-reload timer: COUNT walks 5..1 and irq fires every 5 cycles
    do_reset();
    wr(5'h08, 32'd5);
    wr(5'h10, 32'd3);
    wr(5'h04, 32'h40);
    rd(5'h0C);
    prev_cnt = readdata;
    chk("count_in_range", 32'(prev_cnt >= 1 && prev_cnt <= 5), 32'd1);
    for (int i = 0; i < 9; i++) begin
      rd(5'h0C);
      chk("count_sequence", readdata, (prev_cnt == 1) ? 32'd5 : prev_cnt - 1);
      prev_cnt = readdata;
    end
    wr(5'h00, 32'h40);
    highs = 0;
    last_hi = -1;
    for (int i = 0; i < 20; i++) begin
      wr(5'h00, 32'h40);
      if (interrupts == 8'h40) begin
        if (last_hi >= 0) chk("timer_period", 32'(i - last_hi), 32'd5);
        last_hi = i;
        highs++;
      end
    end
    chk("timer_irq_count", 32'(highs), 32'd4);

    // one-shot: counts down to 0 once, then EN drops
    wr(5'h10, 32'd1);
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      rd(5'h0C);
      if (readdata == 32'd0) found = 1;
    end
    chk("oneshot_reached_zero", 32'(found), 32'd1);
    rd(5'h00);
    chk("oneshot_pend", readdata, 32'h40);
    rd(5'h10);
    chk("oneshot_ctrl", readdata, 32'd0);
    rd(5'h0C);
    chk("oneshot_count_idle", readdata, 32'd0);

    // set beats W1C on the same PEND bit
    do_reset();
    step(1'b0, 1'b0, 1'b0, BASE, 0, 6'h02);
    step(1'b0, 1'b0, 1'b0, BASE, 0, 6'h00);
    step(1'b0, 1'b1, 1'b0, BASE, 32'h2, 6'h02);
    step(1'b0, 1'b0, 1'b1, BASE, 0, 6'h02);
    chk("set_wins_w1c", readdata, 32'h2);

    // reset mid-count with pending requests
    do_reset();
    wr(5'h08, 32'd3);
    wr(5'h10, 32'd3);
    wr(5'h04, 32'hFF);
    wr(5'h14, 32'd1);
    step(1'b0, 1'b0, 1'b0, BASE, 0, 6'h01);
    step(1'b0, 1'b0, 1'b0, BASE, 0, 6'h00);
    step(1'b0, 1'b0, 1'b0, BASE, 0, 6'h00);
    rd(5'h00);
    chk("pre_reset_pend", readdata, 32'hC1);
    do_reset();
    chk("midreset_interrupts", {24'd0, interrupts}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd(5'(i * 4));
      chk($sformatf("midreset_reg%0d", i), readdata, 32'd0);
    end
    chk("midreset_interrupts_hold", {24'd0, interrupts}, 32'd0);

    // random traffic against the model
    do_reset();
    ext = 6'd0;
    for (int i = 0; i < 2000; i++) begin
      word = 5'($urandom_range(0, 7) * 4);
      off  = ($urandom_range(0, 9) == 0);
      adr  = (off ? BASE + 32'h40 : BASE) + 32'(word) + 32'($urandom_range(0, 3));
      wd   = $urandom;
      if (word == 5'h08) wd = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) ext = 6'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 1)), adr, wd, ext);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
